// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locking arbiter sharing one UART_Xmit between N_REQ byte streams
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [N_REQ-1:0]   Req,
    input  logic [N_REQ-1:0]   Last,
    input  logic [N_REQ*8-1:0] Data,
    output logic [N_REQ-1:0]   Ack,
    output logic [N_REQ-1:0]   Grant,
    output logic               Busy,
    output logic               Err,
    input  logic               ErrClr,
    output logic               WR,
    output logic [31:0]        Din,
    input  logic               TxRDY
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, STROBE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t           state, next;
    logic [PW-1:0]    owner, owner_d, sel, ptr, ptr_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic             sel_ok, locked, locked_d, last_q, last_d;
    logic             take, timeout, done, release_own;
    logic             wr_d, busy_d, err_d;
    logic [N_REQ-1:0] grant_d, ack_d;
    logic [31:0]      din_d;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        return PW'(s >= N_REQ ? s - N_REQ : s);
    endfunction

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state  <= IDLE;
            owner  <= '0;
            ptr    <= '0;
            cnt    <= '0;
            locked <= 1'b0;
            last_q <= 1'b0;
            WR     <= 1'b0;
            Din    <= '0;
            Ack    <= '0;
            Grant  <= '0;
            Busy   <= 1'b0;
            Err    <= 1'b0;
        end else begin
            state  <= next;
            owner  <= owner_d;
            ptr    <= ptr_d;
            cnt    <= cnt_d;
            locked <= locked_d;
            last_q <= last_d;
            WR     <= wr_d;
            Din    <= din_d;
            Ack    <= ack_d;
            Grant  <= grant_d;
            Busy   <= busy_d;
            Err    <= err_d;
        end
    end

    // Mid-packet only the owner may continue; otherwise the lowest offset from ptr wins.
    always_comb begin
        sel    = owner;
        sel_ok = locked && Req[owner];
        if (!locked)
            for (int k = N_REQ - 1; k >= 0; k--)
                if (Req[wrap_add(ptr, k)]) begin
                    sel    = wrap_add(ptr, k);
                    sel_ok = 1'b1;
                end
        next = state;
        unique case (state)
            IDLE:      next = (TxRDY && sel_ok) ? LOAD : IDLE;
            LOAD:      next = STROBE;
            STROBE:    next = WAIT_BUSY;
            WAIT_BUSY: next = !TxRDY ? WAIT_DONE : (cnt == CW'(BUSY_TIMEOUT - 1)) ? IDLE : WAIT_BUSY;
            WAIT_DONE: next = TxRDY ? IDLE : WAIT_DONE;
            default:   next = IDLE;
        endcase
    end

    always_comb begin
        take        = state == IDLE && TxRDY && sel_ok;
        timeout     = state == WAIT_BUSY && TxRDY && cnt == CW'(BUSY_TIMEOUT - 1);
        done        = state == WAIT_DONE && TxRDY;
        release_own = timeout || (done && last_q);
        din_d       = take ? {24'b0, Data[int'(sel)*8 +: 8]} : Din;
        grant_d     = take ? N_REQ'(1) << sel : release_own ? '0 : Grant;
        owner_d     = take ? sel : owner;
        last_d      = take ? Last[sel] : last_q;
        locked_d    = release_own ? 1'b0 : done ? 1'b1 : locked;
        ptr_d       = release_own ? wrap_add(owner, 1) : ptr;
        cnt_d       = state == STROBE ? '0 : (state == WAIT_BUSY && cnt != CW'(BUSY_TIMEOUT)) ? cnt + 1'b1 : cnt;
        err_d       = timeout ? 1'b1 : ErrClr ? 1'b0 : Err;
        wr_d        = next == STROBE;
        ack_d       = wr_d ? Grant : '0;
        busy_d      = next != IDLE;
    end
endmodule
